// File: rtl/axi4_lite_periph_regs_if.sv
// AXI4-Lite bus bundle between the bus master and the peripheral register block.
// The read and write channels are grouped here; clock and reset stay separate ports.
interface axi4_lite_periph_regs_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AWADDR;
    logic                    S_AWVALID;
    logic                    S_AWREADY;
    logic [DATA_WIDTH-1:0]   S_WDATA;
    logic [DATA_WIDTH/8-1:0] S_WSTRB;
    logic                    S_WVALID;
    logic                    S_WREADY;
    logic                    S_BVALID;
    logic                    S_BREADY;
    logic [1:0]              S_BRESP;
    logic [ADDR_WIDTH-1:0]   S_ARADDR;
    logic                    S_ARVALID;
    logic                    S_ARREADY;
    logic [DATA_WIDTH-1:0]   S_RDATA;
    logic                    S_RVALID;
    logic                    S_RREADY;
    logic [1:0]              S_RRESP;

    modport master (
        output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
               S_ARADDR, S_ARVALID, S_RREADY,
        input  S_AWREADY, S_WREADY, S_BVALID, S_BRESP, S_ARREADY, S_RDATA,
               S_RVALID, S_RRESP
    );

    modport slave (
        input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
               S_ARADDR, S_ARVALID, S_RREADY,
        output S_AWREADY, S_WREADY, S_BVALID, S_BRESP, S_ARREADY, S_RDATA,
               S_RVALID, S_RRESP
    );
endinterface

// File: rtl/axi4_lite_periph_regs.sv
// AXI4-Lite register block: CTRL, STATUS, THRESH and NUM_OUT output channel registers,
// with byte-strobed writes, SLVERR decode, output enable and a threshold W1C interrupt.
module axi4_lite_periph_regs #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 2,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    axi4_lite_periph_regs_if.slave       s_axi,
    output logic [NUM_OUT*OUT_WIDTH-1:0] OUT_DATA,
    output logic                         IRQ_OUT
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int NUM_REGS = 3 + NUM_OUT;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_VAL}  rd_state_t;

    wr_state_t wr_state, wr_state_next;
    rd_state_t rd_state, rd_state_next;

    logic                  aw_held, w_held;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  en_q, irq_en_q, pend_q;
    logic [3:0]            last_ch_q;
    logic [OUT_WIDTH-1:0]  thresh_q;
    logic [OUT_WIDTH-1:0]  out_q [NUM_OUT];

    logic aw_ready, w_ready, ar_ready, b_valid, r_valid;
    logic aw_hs, w_hs, ar_hs, b_hs, wr_commit, wr_err, rd_err;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data, wr_old, wr_new, rd_word;
    logic [STRB_W-1:0]     wr_strb;
    logic [DATA_WIDTH-1:0] reg_words [NUM_REGS];
    logic                  unused_bits;

    function automatic logic [DATA_WIDTH-1:0] apply_strobe(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [STRB_W-1:0]     strb
    );
        apply_strobe = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) apply_strobe[b*8 +: 8] = new_v[b*8 +: 8];
        end
    endfunction

    // Readies drop combinationally while reset is held so nothing handshakes during reset.
    assign aw_ready  = ARESETn && (wr_state == WR_IDLE) && !aw_held;
    assign w_ready   = ARESETn && (wr_state == WR_IDLE) && !w_held;
    assign ar_ready  = ARESETn && (rd_state == RD_IDLE);
    assign aw_hs     = s_axi.S_AWVALID && aw_ready;
    assign w_hs      = s_axi.S_WVALID && w_ready;
    assign ar_hs     = s_axi.S_ARVALID && ar_ready;
    assign b_hs      = b_valid && s_axi.S_BREADY;
    assign wr_commit = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_idx  = aw_held ? aw_idx_q : s_axi.S_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_data = w_held ? w_data_q : s_axi.S_WDATA;
    assign wr_strb = w_held ? w_strb_q : s_axi.S_WSTRB;
    assign rd_idx  = s_axi.S_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_err  = (wr_idx >= IDX_W'(NUM_REGS));
    assign rd_err  = (rd_idx >= IDX_W'(NUM_REGS));
    assign wr_new  = apply_strobe(wr_old, wr_data, wr_strb);

    assign unused_bits = ^{s_axi.S_AWADDR[ADDR_LSB-1:0], s_axi.S_ARADDR[ADDR_LSB-1:0], wr_new};

    always_comb begin
        wr_state_next = wr_state;
        b_valid       = 1'b0;
        case (wr_state)
            WR_IDLE: if (wr_commit) wr_state_next = WR_RESP;
            WR_RESP: begin
                b_valid = 1'b1;
                if (s_axi.S_BREADY) wr_state_next = WR_IDLE;
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state;
        r_valid       = 1'b0;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_state_next = RD_VAL;
            RD_VAL: begin
                r_valid = 1'b1;
                if (s_axi.S_RREADY) rd_state_next = RD_IDLE;
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_state_next;
            rd_state <= rd_state_next;
        end
    end

    always_comb begin
        reg_words = '{default: '0};
        reg_words[0] = DATA_WIDTH'({irq_en_q, en_q});
        reg_words[1] = DATA_WIDTH'({last_ch_q, 3'b000, pend_q});
        reg_words[2] = DATA_WIDTH'(thresh_q);
        for (int c = 0; c < NUM_OUT; c++) reg_words[3+c] = DATA_WIDTH'(out_q[c]);
    end

    // Both the read data and the pre-write value for strobe merging come from the same view.
    always_comb begin
        rd_word = '0;
        wr_old  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rd_idx == IDX_W'(r)) rd_word = reg_words[r];
            if (wr_idx == IDX_W'(r)) wr_old  = reg_words[r];
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bresp_q  <= 2'b00;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= s_axi.S_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi.S_WDATA;
                w_strb_q <= s_axi.S_WSTRB;
            end
            if (b_hs) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (wr_commit) bresp_q <= wr_err ? 2'b10 : 2'b00;
            if (ar_hs) begin
                rdata_q <= rd_err ? '0 : rd_word;
                rresp_q <= rd_err ? 2'b10 : 2'b00;
            end
        end
    end

    // A threshold crossing is assigned after the W1C clear so that setting wins.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            pend_q    <= 1'b0;
            last_ch_q <= '0;
            thresh_q  <= '0;
            for (int c = 0; c < NUM_OUT; c++) out_q[c] <= '0;
        end else if (wr_commit && !wr_err && (|wr_strb)) begin
            if (wr_idx == IDX_W'(0)) begin
                en_q     <= wr_new[0];
                irq_en_q <= wr_new[1];
            end
            if ((wr_idx == IDX_W'(1)) && wr_strb[0] && wr_data[0]) pend_q <= 1'b0;
            if (wr_idx == IDX_W'(2)) thresh_q <= wr_new[OUT_WIDTH-1:0];
            for (int c = 0; c < NUM_OUT; c++) begin
                if (wr_idx == IDX_W'(3 + c)) begin
                    out_q[c] <= wr_new[OUT_WIDTH-1:0];
                    if (wr_new[OUT_WIDTH-1:0] > thresh_q) begin
                        pend_q    <= 1'b1;
                        last_ch_q <= 4'(c);
                    end
                end
            end
        end
    end

    always_comb begin
        OUT_DATA = '0;
        for (int c = 0; c < NUM_OUT; c++) begin
            if (en_q) OUT_DATA[c*OUT_WIDTH +: OUT_WIDTH] = out_q[c];
        end
    end

    assign IRQ_OUT         = pend_q && irq_en_q;
    assign s_axi.S_AWREADY = aw_ready;
    assign s_axi.S_WREADY  = w_ready;
    assign s_axi.S_BVALID  = b_valid;
    assign s_axi.S_BRESP   = bresp_q;
    assign s_axi.S_ARREADY = ar_ready;
    assign s_axi.S_RVALID  = r_valid;
    assign s_axi.S_RDATA   = rdata_q;
    assign s_axi.S_RRESP   = rresp_q;
endmodule

// File: tb/tb_axi4_lite_periph_regs.sv
// Self-checking bench for axi4_lite_periph_regs: directed scenarios plus randomized traffic
// compared against a register-map level model of the peripheral.
module tb_axi4_lite_periph_regs;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [15:0] OUT_DATA;
    logic        IRQ_OUT;
    int          vectors = 0;
    int          miscompares = 0;

    axi4_lite_periph_regs_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    axi4_lite_periph_regs #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_OUT(2), .OUT_WIDTH(8)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .s_axi(bus), .OUT_DATA(OUT_DATA), .IRQ_OUT(IRQ_OUT)
    );

    always #5 ACLK = ~ACLK;

    // Reference model of the register map
    logic       m_en, m_irq_en, m_pend;
    logic [3:0] m_last;
    logic [7:0] m_thresh;
    logic [7:0] m_out [2];
    logic [15:0] out_at_b;
    logic        irq_at_b;
    int          b_wait;

    task automatic model_reset();
        m_en = 0; m_irq_en = 0; m_pend = 0; m_last = 0; m_thresh = 0;
        m_out[0] = 0; m_out[1] = 0;
    endtask

    function automatic logic [15:0] model_out_data();
        return m_en ? {m_out[1], m_out[0]} : 16'h0000;
    endfunction

    function automatic logic model_irq();
        return m_pend & m_irq_en;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] addr, output logic [1:0] resp);
        int idx = int'(addr >> 2);
        resp = 2'b00;
        case (idx)
            0: return {30'b0, m_irq_en, m_en};
            1: return {24'b0, m_last, 3'b000, m_pend};
            2: return {24'b0, m_thresh};
            3, 4: return {24'b0, m_out[idx-3]};
            default: begin resp = 2'b10; return 32'h0; end
        endcase
    endfunction

    task automatic model_write(input logic [7:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        int idx = int'(addr >> 2);
        logic [7:0] nv;
        resp = 2'b00;
        if (idx >= 5) begin resp = 2'b10; return; end
        if (strb == 4'h0) return;
        case (idx)
            0: if (strb[0]) begin m_en = data[0]; m_irq_en = data[1]; end
            1: if (strb[0] && data[0]) m_pend = 0;
            2: if (strb[0]) m_thresh = data[7:0];
            default: begin
                nv = strb[0] ? data[7:0] : m_out[idx-3];
                m_out[idx-3] = nv;
                if (nv > m_thresh) begin m_pend = 1; m_last = 4'(idx - 3); end
            end
        endcase
    endtask

    task automatic wait_bresp(output logic [1:0] resp);
        int cnt = 0;
        while (!bus.S_BVALID && cnt < 50) begin @(negedge ACLK); cnt++; end
        b_wait = cnt;
        if (!bus.S_BVALID) begin
            vectors++; miscompares++;
            $display("[TB] FAIL b_timeout: BVALID got 0 required 1");
            resp = 2'bxx;
        end else begin
            resp = bus.S_BRESP; out_at_b = OUT_DATA; irq_at_b = IRQ_OUT;
            bus.S_BREADY = 1;
            @(posedge ACLK); #1;
            bus.S_BREADY = 0;
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int cnt = 0;
        @(negedge ACLK);
        bus.S_AWADDR = addr; bus.S_AWVALID = 1;
        bus.S_WDATA = data; bus.S_WSTRB = strb; bus.S_WVALID = 1;
        while (!(aw_done && w_done) && cnt < 50) begin
            aw_fire = bus.S_AWVALID && bus.S_AWREADY;
            w_fire  = bus.S_WVALID && bus.S_WREADY;
            @(posedge ACLK); #1;
            if (aw_fire) begin bus.S_AWVALID = 0; aw_done = 1; end
            if (w_fire)  begin bus.S_WVALID = 0;  w_done = 1;  end
            @(negedge ACLK); cnt++;
        end
        bus.S_AWVALID = 0; bus.S_WVALID = 0;
        wait_bresp(resp);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cnt = 0;
        @(negedge ACLK);
        bus.S_ARADDR = addr; bus.S_ARVALID = 1;
        while (!bus.S_ARREADY && cnt < 50) begin @(negedge ACLK); cnt++; end
        @(posedge ACLK); #1;
        bus.S_ARVALID = 0;
        @(negedge ACLK);
        cnt = 0;
        while (!bus.S_RVALID && cnt < 50) begin @(negedge ACLK); cnt++; end
        if (!bus.S_RVALID) begin
            vectors++; miscompares++;
            $display("[TB] FAIL r_timeout: RVALID got 0 required 1");
            data = 'x; resp = 2'bxx;
        end else begin
            data = bus.S_RDATA; resp = bus.S_RRESP;
            bus.S_RREADY = 1;
            @(posedge ACLK); #1;
            bus.S_RREADY = 0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r;
        ARESETn = 0;
        bus.S_AWADDR = 0; bus.S_AWVALID = 0; bus.S_WDATA = 0; bus.S_WSTRB = 0; bus.S_WVALID = 0;
        bus.S_BREADY = 0; bus.S_ARADDR = 0; bus.S_ARVALID = 0; bus.S_RREADY = 0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        vectors++;
        if ({bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_readies: got %b required 000", {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY});
        end
        vectors++;
        if ({bus.S_BVALID, bus.S_RVALID, bus.S_BRESP, bus.S_RRESP} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_resp: got %b required 000000", {bus.S_BVALID, bus.S_RVALID, bus.S_BRESP, bus.S_RRESP});
        end
        vectors++;
        if ({bus.S_RDATA, OUT_DATA, IRQ_OUT} !== 49'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: RDATA %h OUT_DATA %h IRQ %b required all 0", bus.S_RDATA, OUT_DATA, IRQ_OUT);
        end
        ARESETn = 1;
        #1;
        vectors++;
        if ({bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY} !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL release_readies: got %b required 111", {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY});
        end
        model_reset();
        axi_read(8'h00, d, r);
        vectors++;
        if (d !== 32'h0 || r !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_read_ctrl: got %h/%b required 00000000/00", d, r);
        end
    endtask

    task automatic test_basic_write();
        logic [1:0] r, er; logic [31:0] d, ed;
        axi_write(8'h00, 32'h1, 4'hF, r); model_write(8'h00, 32'h1, 4'hF, er);
        axi_write(8'h10, 32'hA5, 4'hF, r); model_write(8'h10, 32'hA5, 4'hF, er);
        vectors++;
        if (r !== er || b_wait != 0) begin
            miscompares++;
            $display("[TB] FAIL basic_bresp: resp %b wait %0d required %b wait 0", r, b_wait, er);
        end
        vectors++;
        if (out_at_b !== model_out_data()) begin
            miscompares++;
            $display("[TB] FAIL basic_out: got %h required %h", out_at_b, model_out_data());
        end
        axi_write(8'h00, 32'h0, 4'hF, r); model_write(8'h00, 32'h0, 4'hF, er);
        vectors++;
        if (out_at_b !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL basic_disable: got %h required 0000", out_at_b);
        end
        axi_read(8'h10, d, r);
        ed = model_read(8'h10, er);
        vectors++;
        if (d !== ed || r !== er) begin
            miscompares++;
            $display("[TB] FAIL basic_readback: got %h/%b required %h/%b", d, r, ed, er);
        end
    endtask

    task automatic test_split_backpressure();
        logic [1:0] r, er, b0; logic [31:0] d, ed; int cnt = 0;
        @(negedge ACLK);
        bus.S_AWADDR = 8'h0C; bus.S_AWVALID = 1;
        while (!bus.S_AWREADY && cnt < 50) begin @(negedge ACLK); cnt++; end
        @(posedge ACLK); #1; bus.S_AWVALID = 0;
        @(negedge ACLK);
        vectors++;
        if (bus.S_AWREADY !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL split_awready_hold: got %b required 0", bus.S_AWREADY);
        end
        repeat (2) @(negedge ACLK);
        bus.S_WDATA = 32'h3C; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1;
        cnt = 0;
        while (!bus.S_WREADY && cnt < 50) begin @(negedge ACLK); cnt++; end
        @(posedge ACLK); #1; bus.S_WVALID = 0;
        model_write(8'h0C, 32'h3C, 4'hF, er);
        @(negedge ACLK);
        b0 = bus.S_BRESP;
        bus.S_AWADDR = 8'h08; bus.S_AWVALID = 1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.S_BVALID !== 1'b1 || bus.S_BRESP !== er || bus.S_BRESP !== b0 || bus.S_AWREADY !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL split_b_stable: BVALID %b BRESP %b AWREADY %b required 1 %b 0",
                         bus.S_BVALID, bus.S_BRESP, bus.S_AWREADY, er);
            end
            @(negedge ACLK);
        end
        bus.S_BREADY = 1;
        @(posedge ACLK); #1; bus.S_BREADY = 0;
        vectors++;
        if (bus.S_AWREADY !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL split_aw_after_b: got %b required 1", bus.S_AWREADY);
        end
        @(posedge ACLK); #1; bus.S_AWVALID = 0;
        bus.S_WDATA = 32'h05; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1;
        @(negedge ACLK);
        cnt = 0;
        while (!bus.S_WREADY && cnt < 50) begin @(negedge ACLK); cnt++; end
        @(posedge ACLK); #1; bus.S_WVALID = 0;
        @(negedge ACLK);
        wait_bresp(r);
        model_write(8'h08, 32'h05, 4'hF, er);
        axi_read(8'h08, d, r);
        ed = model_read(8'h08, er);
        vectors++;
        if (d !== ed || r !== er) begin
            miscompares++;
            $display("[TB] FAIL split_second_write: got %h/%b required %h/%b", d, r, ed, er);
        end
    endtask

    task automatic test_slverr();
        logic [1:0] r, er; logic [31:0] d, ed;
        axi_write(8'h14, $urandom, 4'hF, r); model_write(8'h14, 32'h0, 4'hF, er);
        vectors++;
        if (r !== 2'b10 || r !== er) begin
            miscompares++;
            $display("[TB] FAIL slverr_write: got %b required 10", r);
        end
        axi_read(8'h40, d, r);
        vectors++;
        if (d !== 32'h0 || r !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL slverr_read: got %h/%b required 00000000/10", d, r);
        end
        for (int a = 0; a < 5; a++) begin
            axi_read(8'(a * 4), d, r);
            ed = model_read(8'(a * 4), er);
            vectors++;
            if (d !== ed || r !== er) begin
                miscompares++;
                $display("[TB] FAIL slverr_regs_word%0d: got %h/%b required %h/%b", a, d, r, ed, er);
            end
        end
    endtask

    task automatic test_irq();
        logic [1:0] r, er; logic [31:0] d, ed;
        axi_write(8'h08, 32'h10, 4'hF, r); model_write(8'h08, 32'h10, 4'hF, er);
        axi_write(8'h00, 32'h3, 4'hF, r);  model_write(8'h00, 32'h3, 4'hF, er);
        axi_write(8'h0C, 32'h11, 4'hF, r); model_write(8'h0C, 32'h11, 4'hF, er);
        vectors++;
        if (irq_at_b !== 1'b1 || irq_at_b !== model_irq()) begin
            miscompares++;
            $display("[TB] FAIL irq_set: got %b required 1", irq_at_b);
        end
        axi_read(8'h04, d, r);
        ed = model_read(8'h04, er);
        vectors++;
        if (d !== ed || d !== 32'h01) begin
            miscompares++;
            $display("[TB] FAIL irq_status: got %h required %h", d, ed);
        end
        axi_write(8'h04, 32'h1, 4'hF, r); model_write(8'h04, 32'h1, 4'hF, er);
        vectors++;
        if (irq_at_b !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL irq_w1c: got %b required 0", irq_at_b);
        end
        axi_write(8'h0C, 32'h10, 4'hF, r); model_write(8'h0C, 32'h10, 4'hF, er);
        vectors++;
        if (irq_at_b !== model_irq() || irq_at_b !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL irq_equal_thresh: got %b required 0", irq_at_b);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r, er; logic [31:0] d, ed;
        axi_write(8'h08, 32'h10, 4'hF, r);       model_write(8'h08, 32'h10, 4'hF, er);
        axi_write(8'h08, 32'hFFFF_FF00, 4'h2, r); model_write(8'h08, 32'hFFFF_FF00, 4'h2, er);
        axi_read(8'h08, d, r);
        ed = model_read(8'h08, er);
        vectors++;
        if (d !== ed || d !== 32'h10 || r !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL strobe_lane1: got %h/%b required %h/00", d, r, ed);
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] wr, rr, er; logic [31:0] d, ed, wd;
        wd = {24'h0, 8'($urandom)};
        ed = model_read(8'h0C, er);
        fork
            axi_write(8'h0C, wd, 4'hF, wr);
            axi_read(8'h0C, d, rr);
        join
        vectors++;
        if (d !== ed || rr !== 2'b00 || wr !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL concurrent_pre_write: got %h/%b required %h/00", d, rr, ed);
        end
        model_write(8'h0C, wd, 4'hF, er);
        vectors++;
        if (out_at_b !== model_out_data()) begin
            miscompares++;
            $display("[TB] FAIL concurrent_out: got %h required %h", out_at_b, model_out_data());
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r, er; logic [31:0] d, ed; int cnt = 0;
        @(negedge ACLK);
        bus.S_AWADDR = 8'h10; bus.S_AWVALID = 1;
        while (!bus.S_AWREADY && cnt < 50) begin @(negedge ACLK); cnt++; end
        @(posedge ACLK); #1; bus.S_AWVALID = 0;
        @(negedge ACLK);
        ARESETn = 0;
        @(posedge ACLK); #1; ARESETn = 1;
        model_reset();
        @(negedge ACLK);
        vectors++;
        if ({bus.S_BVALID, bus.S_AWREADY, bus.S_WREADY} !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_drop: got %b required 011", {bus.S_BVALID, bus.S_AWREADY, bus.S_WREADY});
        end
        bus.S_WDATA = 32'h77; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1;
        @(posedge ACLK); #1; bus.S_WVALID = 0;
        repeat (3) @(negedge ACLK);
        vectors++;
        if (bus.S_BVALID !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_no_resp: got %b required 0", bus.S_BVALID);
        end
        bus.S_AWADDR = 8'h10; bus.S_AWVALID = 1;
        @(posedge ACLK); #1; bus.S_AWVALID = 0;
        @(negedge ACLK);
        wait_bresp(r);
        model_write(8'h10, 32'h77, 4'hF, er);
        axi_read(8'h10, d, r);
        ed = model_read(8'h10, er);
        vectors++;
        if (d !== ed || r !== er) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_rewrite: got %h/%b required %h/%b", d, r, ed, er);
        end
    endtask

    task automatic test_random();
        logic [7:0] addr; logic [31:0] data, d, ed; logic [3:0] strb; logic [1:0] r, er;
        for (int i = 0; i < 80; i++) begin
            addr = {3'($urandom_range(0, 7)), 3'b000, 2'($urandom)} >> 3 << 2 | 8'($urandom_range(0, 3));
            addr = {1'b0, 3'($urandom_range(0, 7)), 2'b00, 2'($urandom)};
            addr = {3'b000, addr[6:4], addr[1:0]};
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                axi_write(addr, data, strb, r);
                model_write(addr, data, strb, er);
                vectors++;
                if (r !== er || out_at_b !== model_out_data() || irq_at_b !== model_irq()) begin
                    miscompares++;
                    $display("[TB] FAIL rand_write_%0d: addr %h resp %b out %h irq %b required %b %h %b",
                             i, addr, r, out_at_b, irq_at_b, er, model_out_data(), model_irq());
                end
            end else begin
                axi_read(addr, d, r);
                ed = model_read(addr, er);
                vectors++;
                if (d !== ed || r !== er) begin
                    miscompares++;
                    $display("[TB] FAIL rand_read_%0d: addr %h got %h/%b required %h/%b", i, addr, d, r, ed, er);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_write();
        test_split_backpressure();
        test_slverr();
        test_irq();
        test_strobe();
        test_concurrent();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
